// File: rtl/serial_adder_arbiter.sv
// ============================================================================
// serial_adder_arbiter : round-robin scheduler sharing one serial adder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int ADD_LAT = 9
) (
  input  logic               clock_arb_i,
  input  logic               resetn_arb_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] a_i,
  input  logic [N*WIDTH-1:0] b_i,
  output logic [N-1:0]       gnt_o,
  output logic [N-1:0]       rsp_valid_o,
  output logic [WIDTH:0]     rsp_sum_o,
  output logic               busy_o,
  output logic               add_start_o,
  output logic [WIDTH-1:0]   add_a_o,
  output logic [WIDTH-1:0]   add_b_o,
  input  logic [WIDTH:0]     add_sum_i
);

  localparam int IDW  = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_d;
  logic            hit_d;
  logic [CNTW-1:0] cnt_q;

  // Scan from ptr upwards; descending loop lets the nearest requester win.
  always_comb begin
    id_d  = '0;
    hit_d = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (req_i[k]) begin
        id_d  = IDW'(k);
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_arb_i) begin
    if (!resetn_arb_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_sum_o   <= '0;
      busy_o      <= 1'b0;
      add_start_o <= 1'b0;
      add_a_o     <= '0;
      add_b_o     <= '0;
    end else begin
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      add_start_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hit_d) begin
            id_q        <= id_d;
            add_a_o     <= a_i[id_d*WIDTH +: WIDTH];
            add_b_o     <= b_i[id_d*WIDTH +: WIDTH];
            gnt_o       <= {{(N-1){1'b0}}, 1'b1} << id_d;
            add_start_o <= 1'b1;
            busy_o      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CNTW'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The adder result is stable in the last WAIT cycle.
          if (cnt_q == CNTW'(ADD_LAT)) begin
            rsp_sum_o   <= add_sum_i;
            rsp_valid_o <= {{(N-1){1'b0}}, 1'b1} << id_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        S_RESP: begin
          ptr_q   <= (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_arbiter.sv
// ============================================================================
// tb_serial_adder_arbiter : self-checking bench with a schedule-level model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_arbiter;

  localparam int WIDTH   = 8;
  localparam int N       = 4;
  localparam int ADD_LAT = 9;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] a = '0;
  logic [N*WIDTH-1:0] b = '0;
  logic [N-1:0]       gnt_o, rsp_valid_o;
  logic [WIDTH:0]     rsp_sum_o;
  logic               busy_o, add_start_o;
  logic [WIDTH-1:0]   add_a_o, add_b_o;
  logic [WIDTH:0]     add_sum = '0;

  serial_adder_arbiter #(.WIDTH(WIDTH), .N(N), .ADD_LAT(ADD_LAT)) dut (
    .clock_arb_i (clk),
    .resetn_arb_i(rstn),
    .req_i       (req),
    .a_i         (a),
    .b_i         (b),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_sum_o   (rsp_sum_o),
    .busy_o      (busy_o),
    .add_start_o (add_start_o),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_sum_i   (add_sum)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT event (t=%0t)", name, $time);
  endtask

  // Adder stand-in: result only valid ADD_LAT cycles after start, garbage before.
  int             ak = 1000;
  logic [WIDTH:0] asum = '0;
  always @(negedge clk) begin
    if (add_start_o === 1'b1) begin
      ak   = 0;
      asum = {1'b0, add_a_o} + {1'b0, add_b_o};
    end else if (ak < 1000) begin
      ak++;
    end
    add_sum = (ak >= ADD_LAT) ? asum : (asum ^ 9'h155);
  end

  // Schedule model: each accepted request owns cycles [gnt, gnt+ADD_LAT+1].
  longint         cyc = 0;
  longint         gnt_cyc = -1, rsp_cyc = -1, free_at = 0;
  int             m_ptr = 0, m_id = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [WIDTH:0] m_sum = '0;

  always @(posedge clk) begin : model
    bit found;
    int kk;
    cyc = cyc + 1;
    if (!rstn) begin
      m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; m_sum = '0;
      gnt_cyc = -1; rsp_cyc = -1; free_at = cyc;
    end else if (cyc == rsp_cyc) begin
      m_sum = {1'b0, m_a} + {1'b0, m_b};
      m_ptr = (m_id + 1) % N;
    end else if (cyc - 1 >= free_at && req != '0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        kk = (m_ptr + i) % N;
        if (!found && req[kk]) begin
          found = 1'b1;
          m_id  = kk;
        end
      end
      m_a     = a[m_id*WIDTH +: WIDTH];
      m_b     = b[m_id*WIDTH +: WIDTH];
      gnt_cyc = cyc;
      rsp_cyc = cyc + ADD_LAT + 1;
      free_at = rsp_cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg, ev;
    if (cyc > 0) begin
      eg = (cyc == gnt_cyc) ? (N'(1) << m_id) : '0;
      ev = (cyc == rsp_cyc) ? (N'(1) << m_id) : '0;
      chk("gnt_o", gnt_o, eg);
      chk("add_start_o", add_start_o, cyc == gnt_cyc);
      chk("rsp_valid_o", rsp_valid_o, ev);
      chk("busy_o", busy_o, (cyc >= gnt_cyc) && (cyc <= rsp_cyc));
      chk("add_a_o", add_a_o, m_a);
      chk("add_b_o", add_b_o, m_b);
      chk("rsp_sum_o", rsp_sum_o, m_sum);
      chk("gnt_rsp_overlap", (gnt_o != '0) && (rsp_valid_o != '0), 1'b0);
    end
  end

  task automatic set_op(input int k, input int av, input int bv);
    a[k*WIDTH +: WIDTH] = WIDTH'(av);
    b[k*WIDTH +: WIDTH] = WIDTH'(bv);
  endtask

  task automatic do_op(input int k, input int av, input int bv, output logic [WIDTH:0] s);
    int t;
    set_op(k, av, bv);
    req[k] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt_o[k] !== 1'b1 && t < 40);
    if (gnt_o[k] !== 1'b1) tmo("do_op_gnt");
    req[k] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid_o[k] !== 1'b1 && t < 40);
    if (rsp_valid_o[k] !== 1'b1) begin
      tmo("do_op_rsp");
      s = 'x;
    end else begin
      s = rsp_sum_o;
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin : stim
    logic [WIDTH:0] s;
    int t, ng, cnt, done;
    int gid[5];
    longint gcy[5];

    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_sum", rsp_sum_o, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single request, exact latency
    set_op(0, 235, 251);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", gnt_o, 4'b0001);
    chk("t1_start", add_start_o, 1);
    chk("t1_add_a", add_a_o, 235);
    req = '0;
    @(negedge clk);
    chk("t1_start_low", add_start_o, 0);
    repeat (9) @(negedge clk);
    chk("t1_rsp_valid", rsp_valid_o, 4'b0001);
    chk("t1_sum", rsp_sum_o, 9'h1E6);
    @(negedge clk);

    // 5: edge operand values (ptr now 1)
    do_op(1, 255, 255, s); chk("t5_510", s, 510);
    do_op(2, 0, 0, s);     chk("t5_0", s, 0);
    do_op(3, 128, 128, s); chk("t5_256", s, 256);
    @(negedge clk);

    // 2: all requesters held continuously
    for (int k = 0; k < N; k++) set_op(k, 17 * k + 3, 250 - 31 * k);
    req = 4'b1111;
    ng = 0; t = 0;
    while (ng < 5 && t < 100) begin
      @(negedge clk); t++;
      if (gnt_o != '0) begin
        gid[ng] = oh2id(gnt_o);
        gcy[ng] = cyc;
        ng++;
      end
    end
    req = '0;
    if (ng < 5) tmo("t2_grants");
    else begin
      chk("t2_g0", gid[0], 0); chk("t2_g1", gid[1], 1);
      chk("t2_g2", gid[2], 2); chk("t2_g3", gid[3], 3);
      chk("t2_g4", gid[4], 0);
      for (int i = 0; i < 4; i++) chk("t2_spacing", 32'(gcy[i+1] - gcy[i]), 12);
    end
    repeat (14) @(negedge clk);

    // 3: wrap-around ordering
    do_op(1, 9, 8, s); chk("t3_pre_sum", s, 17);
    set_op(0, 1, 2); set_op(3, 3, 4);
    req = 4'b1001;
    ng = 0; t = 0;
    while (ng < 2 && t < 60) begin
      @(negedge clk); t++;
      if (gnt_o != '0) begin
        gid[ng] = oh2id(gnt_o);
        req = req & ~gnt_o;
        ng++;
      end
    end
    req = '0;
    if (ng < 2) tmo("t3_grants");
    else begin
      chk("t3_first", gid[0], 3);
      chk("t3_second", gid[1], 0);
    end
    repeat (14) @(negedge clk);

    // 4: reset in WAIT cycle 4
    set_op(0, 77, 88);
    req = 4'b0001;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt_o[0] !== 1'b1 && t < 40);
    if (gnt_o[0] !== 1'b1) tmo("t4_gnt");
    req = '0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("t4_gnt0", gnt_o, 0);
    chk("t4_rsp0", rsp_valid_o, 0);
    chk("t4_busy0", busy_o, 0);
    chk("t4_start0", add_start_o, 0);
    chk("t4_a0", add_a_o, 0);
    chk("t4_b0", add_b_o, 0);
    chk("t4_sum0", rsp_sum_o, 0);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    set_op(2, 40, 60);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_gnt2", gnt_o, 4'b0100);
    req = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid_o[2] !== 1'b1 && t < 40);
    chk("t4_sum", rsp_sum_o, 100);
    @(negedge clk);

    // 6: request raised while busy
    set_op(0, 5, 6);
    req = 4'b0001;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt_o[0] !== 1'b1 && t < 40);
    if (gnt_o[0] !== 1'b1) tmo("t6_gnt0");
    req = '0;
    cnt = 0;
    do begin
      @(negedge clk); cnt++;
      if (cnt == 4) begin
        chk("t6_busy_mid", busy_o, 1);
        set_op(2, 200, 100);
        req[2] = 1'b1;
      end
    end while (gnt_o[2] !== 1'b1 && cnt < 40);
    chk("t6_gnt2_delay", cnt, 12);
    req = '0;
    repeat (14) @(negedge clk);

    // random traffic: requests held until granted
    done = 0; t = 0;
    while (done < 200 && t < 8000) begin
      @(negedge clk); t++;
      if (rsp_valid_o != '0) done++;
      for (int k = 0; k < N; k++) begin
        if (req[k] && gnt_o[k]) req[k] = 1'b0;
        else if (!req[k] && !gnt_o[k] && $urandom_range(0, 3) == 0) begin
          set_op(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
          req[k] = 1'b1;
        end
      end
    end
    if (done < 200) tmo("random_ops");
    req = '0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
